// File: rtl/pep_batch_scheduler_pkg.sv
// Shared definitions for the PBS batch scheduler: default batch geometry,
// derived widths and the scheduler state encoding.
package pep_batch_scheduler_pkg;

  localparam int TOTAL_PBS_NB = 27;
  localparam int BATCH_PBS_NB = 12;
  localparam int BATCH_NB     = 1;
  localparam int GRAM_NB      = 3;

  localparam int PID_W = $clog2(TOTAL_PBS_NB);
  localparam int BNB_W = $clog2(BATCH_PBS_NB + 1);
  localparam int GID_W = $clog2(GRAM_NB);
  localparam int IFL_W = $clog2(BATCH_NB + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  typedef logic [PID_W-1:0]        pid_t;
  typedef logic [TOTAL_PBS_NB-1:0] mask_t;
  typedef logic [BNB_W-1:0]        bnb_t;

endpackage

// File: rtl/pep_batch_free_pool.sv
// PBS slot pool: free mask, free counter, lowest-free allocation and
// release with double-release detection.
module pep_batch_free_pool #(
  parameter int  TOTAL_PBS_NB = pep_batch_scheduler_pkg::TOTAL_PBS_NB,
  parameter int  GRAM_NB      = pep_batch_scheduler_pkg::GRAM_NB,
  localparam int PID_W        = $clog2(TOTAL_PBS_NB),
  localparam int GID_W        = $clog2(GRAM_NB)
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             alloc,
  output logic [PID_W-1:0] alloc_pid,
  output logic [GID_W-1:0] alloc_gid,
  output logic             avail,
  output logic             empty_next,
  input  logic             rel_vld,
  input  logic [PID_W-1:0] rel_pid,
  output logic             rel_err,
  output logic [PID_W:0]   free_cnt
);
  import pep_batch_scheduler_pkg::*;

  logic [TOTAL_PBS_NB-1:0] free_mask;
  logic [TOTAL_PBS_NB-1:0] free_mask_n;
  logic [TOTAL_PBS_NB-1:0] alloc_oh;
  logic [TOTAL_PBS_NB-1:0] rel_oh;
  logic                    init_done;
  logic                    alloc_take;
  logic                    rel_in_range;
  logic                    rel_ok;

  // Downward scan so the lowest free index wins.
  always_comb begin
    alloc_pid = '0;
    for (int i = TOTAL_PBS_NB - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_pid = PID_W'(i);
    end
  end

  assign alloc_gid    = GID_W'(alloc_pid % PID_W'(GRAM_NB));
  assign avail        = |free_mask;
  assign alloc_take   = alloc && avail;
  assign alloc_oh     = alloc_take ? ({{(TOTAL_PBS_NB-1){1'b0}}, 1'b1} << alloc_pid) : '0;
  assign rel_oh       = {{(TOTAL_PBS_NB-1){1'b0}}, 1'b1} << rel_pid;
  assign rel_in_range = ({1'b0, rel_pid} < (PID_W+1)'(TOTAL_PBS_NB));
  assign rel_ok       = rel_vld && init_done && rel_in_range && !(|(free_mask & rel_oh));
  assign rel_err      = rel_vld && !rel_ok;

  // The pool comes up empty in reset and fills on the first cycle out of it.
  always_comb begin
    free_mask_n = (free_mask & ~alloc_oh) | (rel_ok ? rel_oh : '0);
    if (!init_done) free_mask_n = '1;
  end

  assign empty_next = ~|free_mask_n;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      init_done <= 1'b0;
      free_mask <= '0;
      free_cnt  <= '0;
    end else begin
      init_done <= 1'b1;
      free_mask <= free_mask_n;
      if (!init_done) free_cnt <= (PID_W+1)'(TOTAL_PBS_NB);
      else            free_cnt <= free_cnt - (PID_W+1)'(alloc_take) + (PID_W+1)'(rel_ok);
    end
  end

endmodule

// File: rtl/pep_batch_scheduler.sv
// PBS batch scheduler: allocates slots to incoming requests, groups them into
// batches closed on size, timeout, flush or pool exhaustion, and tracks batches in flight.
module pep_batch_scheduler #(
  parameter int  TOTAL_PBS_NB = pep_batch_scheduler_pkg::TOTAL_PBS_NB,
  parameter int  BATCH_PBS_NB = pep_batch_scheduler_pkg::BATCH_PBS_NB,
  parameter int  BATCH_NB     = pep_batch_scheduler_pkg::BATCH_NB,
  parameter int  GRAM_NB      = pep_batch_scheduler_pkg::GRAM_NB,
  parameter int  TIMEOUT_W    = 16,
  localparam int PID_W        = $clog2(TOTAL_PBS_NB),
  localparam int BNB_W        = $clog2(BATCH_PBS_NB + 1),
  localparam int GID_W        = $clog2(GRAM_NB),
  localparam int IFL_W        = $clog2(BATCH_NB + 1)
) (
  input  logic                    clk,
  input  logic                    s_rst,
  input  logic                    req_vld,
  output logic                    req_rdy,
  output logic [PID_W-1:0]        req_pid,
  output logic [GID_W-1:0]        req_gid,
  input  logic                    flush,
  input  logic [TIMEOUT_W-1:0]    timeout_cfg,
  output logic                    batch_vld,
  input  logic                    batch_rdy,
  output logic [BNB_W-1:0]        batch_pbs_nb,
  output logic [TOTAL_PBS_NB-1:0] batch_pid_mask,
  input  logic                    batch_done,
  input  logic                    rel_vld,
  input  logic [PID_W-1:0]        rel_pid,
  output logic [PID_W:0]          free_cnt,
  output logic [IFL_W-1:0]        inflight_cnt,
  output logic                    err
);
  import pep_batch_scheduler_pkg::*;

  // Handshakes: a transfer happens on a cycle where valid && ready at posedge clk.
  // req_rdy and batch_vld depend only on registered state, never on the peer's
  // valid/ready, and batch_vld with its payload stays stable until batch_rdy.

  state_e                  state;
  state_e                  state_n;
  logic [BNB_W-1:0]        count;
  logic [BNB_W-1:0]        count_n;
  logic [TIMEOUT_W-1:0]    timer;
  logic [TIMEOUT_W-1:0]    timer_n;
  logic [TOTAL_PBS_NB-1:0] open_mask;
  logic [TOTAL_PBS_NB-1:0] open_mask_n;
  logic                    accept;
  logic                    handshake;
  logic                    tmo_hit;
  logic                    done_ok;
  logic                    pool_avail;
  logic                    pool_empty_next;
  logic                    pool_rel_err;

  pep_batch_free_pool #(
    .TOTAL_PBS_NB(TOTAL_PBS_NB),
    .GRAM_NB     (GRAM_NB)
  ) u_pool (
    .clk       (clk),
    .s_rst     (s_rst),
    .alloc     (accept),
    .alloc_pid (req_pid),
    .alloc_gid (req_gid),
    .avail     (pool_avail),
    .empty_next(pool_empty_next),
    .rel_vld   (rel_vld),
    .rel_pid   (rel_pid),
    .rel_err   (pool_rel_err),
    .free_cnt  (free_cnt)
  );

  always_comb begin
    req_rdy   = 1'b0;
    batch_vld = 1'b0;
    unique case (state)
      ST_IDLE:  req_rdy   = pool_avail;
      ST_FILL:  req_rdy   = pool_avail && (count < BNB_W'(BATCH_PBS_NB));
      ST_ISSUE: batch_vld = (inflight_cnt < IFL_W'(BATCH_NB));
      default:  ;
    endcase
  end

  assign accept    = req_vld && req_rdy;
  assign handshake = batch_vld && batch_rdy;
  assign tmo_hit   = (timeout_cfg != '0) && (timer == timeout_cfg);
  assign done_ok   = batch_done && (inflight_cnt != '0);

  // Close conditions look at post-accept values, so a request landing with
  // flush, timeout or the last free slot joins the closing batch.
  always_comb begin
    state_n     = state;
    count_n     = count;
    timer_n     = timer;
    open_mask_n = open_mask;
    unique case (state)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          open_mask_n = open_mask | ({{(TOTAL_PBS_NB-1){1'b0}}, 1'b1} << req_pid);
          count_n     = count + BNB_W'(1);
        end
        timer_n = (state == ST_IDLE) ? TIMEOUT_W'(1) : timer + TIMEOUT_W'(1);
        if (state == ST_FILL || accept) begin
          state_n = ST_FILL;
          if ((count_n == BNB_W'(BATCH_PBS_NB)) || pool_empty_next || flush ||
              ((state == ST_FILL) && tmo_hit))
            state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          state_n     = ST_IDLE;
          count_n     = '0;
          open_mask_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      timer        <= '0;
      open_mask    <= '0;
      inflight_cnt <= '0;
      err          <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      timer     <= timer_n;
      open_mask <= open_mask_n;
      if (handshake && !done_ok)      inflight_cnt <= inflight_cnt + IFL_W'(1);
      else if (!handshake && done_ok) inflight_cnt <= inflight_cnt - IFL_W'(1);
      err <= err | pool_rel_err | (batch_done && !done_ok);
    end
  end

  assign batch_pbs_nb   = count;
  assign batch_pid_mask = open_mask;

endmodule

// File: tb/tb_pep_batch_scheduler.sv
// Directed bench for pep_batch_scheduler: inputs change and outputs are sampled
// on the falling clock edge; expected values are hand-computed constants.
module tb_pep_batch_scheduler;
  localparam int TOTAL = 27;
  localparam int PID_W = 5;
  localparam int GID_W = 2;
  localparam int BNB_W = 4;
  localparam int IFL_W = 1;
  localparam int TW    = 16;

  logic             clk = 1'b0;
  logic             s_rst = 1'b1;
  logic             req_vld = 1'b0;
  logic             flush = 1'b0;
  logic             batch_rdy = 1'b0;
  logic             batch_done = 1'b0;
  logic             rel_vld = 1'b0;
  logic [TW-1:0]    timeout_cfg = '0;
  logic [PID_W-1:0] rel_pid = '0;
  logic             req_rdy;
  logic [PID_W-1:0] req_pid;
  logic [GID_W-1:0] req_gid;
  logic             batch_vld;
  logic [BNB_W-1:0] batch_pbs_nb;
  logic [TOTAL-1:0] batch_pid_mask;
  logic [PID_W:0]   free_cnt;
  logic [IFL_W-1:0] inflight_cnt;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;
  int got_pid[$];
  int got_gid[$];
  int push_cycles;

  always #5 clk = ~clk;

  pep_batch_scheduler dut (
    .clk           (clk),
    .s_rst         (s_rst),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_pid       (req_pid),
    .req_gid       (req_gid),
    .flush         (flush),
    .timeout_cfg   (timeout_cfg),
    .batch_vld     (batch_vld),
    .batch_rdy     (batch_rdy),
    .batch_pbs_nb  (batch_pbs_nb),
    .batch_pid_mask(batch_pid_mask),
    .batch_done    (batch_done),
    .rel_vld       (rel_vld),
    .rel_pid       (rel_pid),
    .free_cnt      (free_cnt),
    .inflight_cnt  (inflight_cnt),
    .err           (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    s_rst = 1'b1; req_vld = 1'b0; flush = 1'b0; batch_rdy = 1'b0;
    batch_done = 1'b0; rel_vld = 1'b0; timeout_cfg = '0;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_reqs(input int n);
    got_pid.delete();
    got_gid.delete();
    push_cycles = 0;
    while (got_pid.size() < n && push_cycles < 100) begin
      @(negedge clk);
      push_cycles++;
      if (req_rdy) begin
        req_vld = 1'b1;
        got_pid.push_back(int'(req_pid));
        got_gid.push_back(int'(req_gid));
      end else begin
        req_vld = 1'b0;
      end
    end
    @(negedge clk);
    req_vld = 1'b0;
    if (got_pid.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL push_reqs: accepted %0d required %0d", got_pid.size(), n);
    end
  endtask

  task automatic take_batch();
    batch_rdy = 1'b1;
    @(negedge clk);
    batch_rdy = 1'b0;
  endtask

  task automatic pulse_done();
    batch_done = 1'b1;
    @(negedge clk);
    batch_done = 1'b0;
  endtask

  task automatic release_pid(input int p);
    rel_vld = 1'b1;
    rel_pid = PID_W'(p);
    @(negedge clk);
    rel_vld = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    s_rst = 1'b1;
    @(negedge clk);
    n_checks++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy: got %0b exp 0", req_rdy); end
    n_checks++; if (batch_vld !== 1'b0) begin n_fail++; $display("FAIL rst_batch_vld: got %0b exp 0", batch_vld); end
    n_checks++; if (batch_pbs_nb !== '0) begin n_fail++; $display("FAIL rst_nb: got %0d exp 0", batch_pbs_nb); end
    n_checks++; if (batch_pid_mask !== '0) begin n_fail++; $display("FAIL rst_mask: got %h exp 0", batch_pid_mask); end
    n_checks++; if (req_pid !== '0) begin n_fail++; $display("FAIL rst_pid: got %0d exp 0", req_pid); end
    n_checks++; if (req_gid !== '0) begin n_fail++; $display("FAIL rst_gid: got %0d exp 0", req_gid); end
    n_checks++; if (free_cnt !== '0) begin n_fail++; $display("FAIL rst_free_cnt: got %0d exp 0", free_cnt); end
    n_checks++; if (inflight_cnt !== '0) begin n_fail++; $display("FAIL rst_inflight: got %0d exp 0", inflight_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b exp 0", err); end
    s_rst = 1'b0;
    @(negedge clk);
    n_checks++; if (free_cnt !== 6'd27) begin n_fail++; $display("FAIL post_rst_free_cnt: got %0d exp 27", free_cnt); end
    n_checks++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_rdy: got %0b exp 1", req_rdy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_reqs(12);
    for (int i = 0; i < got_pid.size(); i++) begin
      n_checks++; if (got_pid[i] != i) begin n_fail++; $display("FAIL b2b_pid[%0d]: got %0d exp %0d", i, got_pid[i], i); end
      n_checks++; if (got_gid[i] != i % 3) begin n_fail++; $display("FAIL b2b_gid[%0d]: got %0d exp %0d", i, got_gid[i], i % 3); end
    end
    n_checks++; if (push_cycles != 12) begin n_fail++; $display("FAIL b2b_cycles: got %0d exp 12", push_cycles); end
    n_checks++; if (batch_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_vld: got %0b exp 1", batch_vld); end
    n_checks++; if (batch_pbs_nb !== 4'd12) begin n_fail++; $display("FAIL b2b_nb: got %0d exp 12", batch_pbs_nb); end
    n_checks++; if (batch_pid_mask !== 27'h0000FFF) begin n_fail++; $display("FAIL b2b_mask: got %h exp 0000fff", batch_pid_mask); end
    n_checks++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_issue: got %0b exp 0", req_rdy); end
    n_checks++; if (free_cnt !== 6'd15) begin n_fail++; $display("FAIL b2b_free_cnt: got %0d exp 15", free_cnt); end
    @(negedge clk);
    n_checks++; if (batch_vld !== 1'b1 || batch_pid_mask !== 27'h0000FFF) begin n_fail++; $display("FAIL b2b_hold: vld %0b mask %h exp 1 0000fff", batch_vld, batch_pid_mask); end
    n_checks++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_hold: got %0b exp 0", req_rdy); end
    take_batch();
    n_checks++; if (batch_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_vld_after: got %0b exp 0", batch_vld); end
    n_checks++; if (inflight_cnt !== 1'b1) begin n_fail++; $display("FAIL b2b_inflight: got %0d exp 1", inflight_cnt); end
    n_checks++; if (req_rdy !== 1'b1 || req_pid !== 5'd12) begin n_fail++; $display("FAIL b2b_next: rdy %0b pid %0d exp 1 12", req_rdy, req_pid); end
    n_checks++; if (batch_pid_mask !== '0) begin n_fail++; $display("FAIL b2b_mask_clr: got %h exp 0", batch_pid_mask); end
  endtask

  task automatic test_timeout();
    do_reset();
    timeout_cfg = 16'd8;
    push_reqs(3);
    for (int i = 0; i < got_pid.size(); i++) begin
      n_checks++; if (got_pid[i] != i) begin n_fail++; $display("FAIL tmo_pid[%0d]: got %0d exp %0d", i, got_pid[i], i); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (batch_vld !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d]: got %0b exp 0", k, batch_vld); end
    end
    @(negedge clk);
    n_checks++; if (batch_vld !== 1'b1) begin n_fail++; $display("FAIL tmo_vld: got %0b exp 1", batch_vld); end
    n_checks++; if (batch_pbs_nb !== 4'd3) begin n_fail++; $display("FAIL tmo_nb: got %0d exp 3", batch_pbs_nb); end
    n_checks++; if (batch_pid_mask !== 27'h7) begin n_fail++; $display("FAIL tmo_mask: got %h exp 7", batch_pid_mask); end
    timeout_cfg = '0;
  endtask

  task automatic test_flow_control();
    do_reset();
    push_reqs(12);
    take_batch();
    push_reqs(12);
    n_checks++; if (got_pid.size() != 12 || got_pid[0] != 12 || got_pid[11] != 23) begin n_fail++; $display("FAIL fc_pids: got %0d entries exp 12..23", got_pid.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (batch_vld !== 1'b0 || inflight_cnt !== 1'b1) begin n_fail++; $display("FAIL fc_wait[%0d]: vld %0b ifl %0d exp 0 1", k, batch_vld, inflight_cnt); end
      @(negedge clk);
    end
    batch_done = 1'b1;
    batch_rdy  = 1'b1;
    @(negedge clk);
    batch_done = 1'b0;
    n_checks++; if (inflight_cnt !== 1'b0) begin n_fail++; $display("FAIL fc_done_ifl: got %0d exp 0", inflight_cnt); end
    n_checks++; if (batch_vld !== 1'b1 || batch_pid_mask !== 27'hFFF000) begin n_fail++; $display("FAIL fc_release: vld %0b mask %h exp 1 fff000", batch_vld, batch_pid_mask); end
    @(negedge clk);
    batch_rdy = 1'b0;
    n_checks++; if (inflight_cnt !== 1'b1) begin n_fail++; $display("FAIL fc_hs_ifl: got %0d exp 1", inflight_cnt); end
    n_checks++; if (batch_vld !== 1'b0 || batch_pbs_nb !== '0) begin n_fail++; $display("FAIL fc_hs_clear: vld %0b nb %0d exp 0 0", batch_vld, batch_pbs_nb); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fc_err: got %0b exp 0", err); end
  endtask

  task automatic test_exhaustion();
    do_reset();
    push_reqs(12);
    take_batch();
    pulse_done();
    push_reqs(12);
    n_checks++; if (got_pid.size() != 12 || got_pid[0] != 12 || got_pid[11] != 23) begin n_fail++; $display("FAIL ex_pids2: got %0d entries exp 12..23", got_pid.size()); end
    n_checks++; if (batch_vld !== 1'b1 || batch_pbs_nb !== 4'd12 || batch_pid_mask !== 27'hFFF000) begin n_fail++; $display("FAIL ex_batch2: vld %0b nb %0d mask %h exp 1 12 fff000", batch_vld, batch_pbs_nb, batch_pid_mask); end
    take_batch();
    pulse_done();
    push_reqs(3);
    n_checks++; if (got_pid.size() != 3 || got_pid[0] != 24 || got_pid[2] != 26) begin n_fail++; $display("FAIL ex_pids3: got %0d entries exp 24..26", got_pid.size()); end
    n_checks++; if (batch_vld !== 1'b1) begin n_fail++; $display("FAIL ex_vld3: got %0b exp 1", batch_vld); end
    n_checks++; if (batch_pbs_nb !== 4'd3) begin n_fail++; $display("FAIL ex_nb3: got %0d exp 3", batch_pbs_nb); end
    n_checks++; if (batch_pid_mask !== 27'h7000000) begin n_fail++; $display("FAIL ex_mask3: got %h exp 7000000", batch_pid_mask); end
    n_checks++; if (free_cnt !== '0) begin n_fail++; $display("FAIL ex_free_cnt: got %0d exp 0", free_cnt); end
    take_batch();
    pulse_done();
    n_checks++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL ex_rdy_empty: got %0b exp 0", req_rdy); end
    release_pid(5);
    n_checks++; if (free_cnt !== 6'd1) begin n_fail++; $display("FAIL ex_free_after_rel: got %0d exp 1", free_cnt); end
    n_checks++; if (req_rdy !== 1'b1 || req_pid !== 5'd5) begin n_fail++; $display("FAIL ex_realloc: rdy %0b pid %0d exp 1 5", req_rdy, req_pid); end
    push_reqs(1);
    n_checks++; if (got_pid.size() != 1 || got_pid[0] != 5 || got_gid[0] != 2) begin n_fail++; $display("FAIL ex_pid5: got %0d entries exp pid 5 gid 2", got_pid.size()); end
    n_checks++; if (batch_vld !== 1'b1 || batch_pbs_nb !== 4'd1 || batch_pid_mask !== 27'h20) begin n_fail++; $display("FAIL ex_batch4: vld %0b nb %0d mask %h exp 1 1 20", batch_vld, batch_pbs_nb, batch_pid_mask); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ex_err: got %0b exp 0", err); end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (batch_vld !== 1'b0 || req_rdy !== 1'b1) begin n_fail++; $display("FAIL fl_idle[%0d]: vld %0b rdy %0b exp 0 1", k, batch_vld, req_rdy); end
      @(negedge clk);
    end
    push_reqs(1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (batch_vld !== 1'b1 || batch_pbs_nb !== 4'd1 || batch_pid_mask !== 27'h1) begin n_fail++; $display("FAIL fl_one: vld %0b nb %0d mask %h exp 1 1 1", batch_vld, batch_pbs_nb, batch_pid_mask); end
    take_batch();
    pulse_done();
    req_vld = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    flush   = 1'b0;
    n_checks++; if (batch_vld !== 1'b1 || batch_pbs_nb !== 4'd1 || batch_pid_mask !== 27'h2) begin n_fail++; $display("FAIL fl_same_cycle: vld %0b nb %0d mask %h exp 1 1 2", batch_vld, batch_pbs_nb, batch_pid_mask); end
  endtask

  task automatic test_errors();
    do_reset();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %0b exp 0", err); end
    release_pid(3);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_double_rel: got %0b exp 1", err); end
    repeat (3) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b exp 1", err); end
    n_checks++; if (free_cnt !== 6'd27) begin n_fail++; $display("FAIL err_free_cnt: got %0d exp 27", free_cnt); end
    do_reset();
    pulse_done();
    n_checks++; if (err !== 1'b1 || inflight_cnt !== 1'b0) begin n_fail++; $display("FAIL err_done_idle: err %0b ifl %0d exp 1 0", err, inflight_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_reqs(5);
    n_checks++; if (free_cnt !== 6'd22) begin n_fail++; $display("FAIL rm_free_before: got %0d exp 22", free_cnt); end
    s_rst = 1'b1;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
    n_checks++; if (free_cnt !== 6'd27) begin n_fail++; $display("FAIL rm_free_cnt: got %0d exp 27", free_cnt); end
    n_checks++; if (req_rdy !== 1'b1 || req_pid !== 5'd0) begin n_fail++; $display("FAIL rm_next_pid: rdy %0b pid %0d exp 1 0", req_rdy, req_pid); end
    n_checks++; if (batch_pbs_nb !== '0 || batch_pid_mask !== '0) begin n_fail++; $display("FAIL rm_discard: nb %0d mask %h exp 0 0", batch_pbs_nb, batch_pid_mask); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (batch_vld !== 1'b0) begin n_fail++; $display("FAIL rm_no_batch[%0d]: got %0b exp 0", k, batch_vld); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_flow_control();
    test_exhaustion();
    test_flush();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
